// File: rtl/seq_alu.sv
// Clocked ALU: single-cycle logic/add/sub, WIDTH-cycle shift-add multiply.
// Results are registered and qualified by a one-cycle done strobe.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_hi,
    output logic             co,
    output logic             zero
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t               state_reg, state_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [2*WIDTH-1:0]   a_sh_reg, a_sh_next;
    logic [WIDTH-1:0]     b_sh_reg, b_sh_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [WIDTH-1:0]     c_reg, c_next;
    logic [WIDTH-1:0]     c_hi_reg, c_hi_next;
    logic                 co_reg, co_next;
    logic                 zero_reg, zero_next;
    logic                 done_reg, done_next;

    logic [WIDTH:0]       wide_res;
    logic [2*WIDTH-1:0]   sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            acc_reg   <= '0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            cnt_reg   <= '0;
            c_reg     <= '0;
            c_hi_reg  <= '0;
            co_reg    <= 1'b0;
            zero_reg  <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            cnt_reg   <= cnt_next;
            c_reg     <= c_next;
            c_hi_reg  <= c_hi_next;
            co_reg    <= co_next;
            zero_reg  <= zero_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        cnt_next   = cnt_reg;
        c_next     = c_reg;
        c_hi_next  = c_hi_reg;
        co_next    = co_reg;
        zero_next  = zero_reg;
        done_next  = 1'b0;
        wide_res   = '0;
        sum        = acc_reg + (b_sh_reg[0] ? a_sh_reg : '0);

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_next = S_MUL;
                        a_sh_next  = {{WIDTH{1'b0}}, a};
                        b_sh_next  = b;
                        acc_next   = '0;
                        cnt_next   = '0;
                    end else begin
                        // Bit WIDTH of wide_res carries the carry/borrow.
                        case (op)
                            OP_NOT:  wide_res = {1'b0, ~a};
                            OP_AND:  wide_res = {1'b0, a & b};
                            OP_OR:   wide_res = {1'b0, a | b};
                            OP_XOR:  wide_res = {1'b0, a ^ b};
                            OP_ADD:  wide_res = {1'b0, a} + {1'b0, b};
                            OP_SUB:  wide_res = {1'b0, a} - {1'b0, b};
                            default: wide_res = '0;
                        endcase
                        c_next    = wide_res[WIDTH-1:0];
                        c_hi_next = '0;
                        co_next   = wide_res[WIDTH];
                        zero_next = (wide_res[WIDTH-1:0] == '0);
                        done_next = 1'b1;
                    end
                end
            end
            S_MUL: begin
                // Multiplicand shifts left while multiplier shifts right, so
                // bit 0 of b_sh_reg is always multiplier bit cnt_reg.
                acc_next  = sum;
                a_sh_next = a_sh_reg << 1;
                b_sh_next = b_sh_reg >> 1;
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    c_next     = sum[WIDTH-1:0];
                    c_hi_next  = sum[2*WIDTH-1:WIDTH];
                    co_next    = |sum[2*WIDTH-1:WIDTH];
                    zero_next  = (sum == '0);
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state_reg == S_MUL);
    assign done = done_reg;
    assign c    = c_reg;
    assign c_hi = c_hi_reg;
    assign co   = co_reg;
    assign zero = zero_reg;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8 with hand-computed expectations.
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       busy, done, co, zero;
    logic [7:0] c, c_hi;

    int checks = 0;
    int fails  = 0;
    int dones  = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
        .busy(busy), .done(done), .c(c), .c_hi(c_hi), .co(co), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    task automatic check_out(input string tag, input logic d, input logic bz,
                             input logic [7:0] ec, input logic [7:0] eh,
                             input logic eco, input logic ez);
        check({tag, ".done"}, {31'd0, done}, {31'd0, d});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
        check({tag, ".c"},    {24'd0, c},    {24'd0, ec});
        check({tag, ".c_hi"}, {24'd0, c_hi}, {24'd0, eh});
        check({tag, ".co"},   {31'd0, co},   {31'd0, eco});
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
        $display("txn %-14s done=%0b busy=%0b c=%02h c_hi=%02h co=%0b zero=%0b",
                 tag, done, busy, c, c_hi, co, zero);
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        check_out("reset_hold", 0, 0, 8'h00, 8'h00, 0, 1);
        rst = 1'b0;
        tick();
        check_out("reset", 0, 0, 8'h00, 8'h00, 0, 1);

        // Single-cycle ops back to back
        issue(3'b100, 8'hF0, 8'h20); tick();
        check_out("add_carry", 1, 0, 8'h10, 8'h00, 1, 0);
        issue(3'b101, 8'h05, 8'h07); tick();
        check_out("sub_borrow", 1, 0, 8'hFE, 8'h00, 1, 0);
        issue(3'b011, 8'h5A, 8'h5A); tick();
        check_out("xor_zero", 1, 0, 8'h00, 8'h00, 0, 1);
        start = 1'b0; tick();
        check_out("idle_hold", 0, 0, 8'h00, 8'h00, 0, 1);

        // MUL 0xFF*0xFF with operand toggling during the multiply
        issue(3'b110, 8'hFF, 8'hFF); tick();
        start = 1'b0;
        check_out("mul_ff_k", 0, 1, 8'h00, 8'h00, 0, 1);
        for (int i = 1; i < 8; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            tick();
            check("mul_ff_busy", {31'd0, busy}, 32'd1);
            check("mul_ff_nodone", {31'd0, done}, 32'd0);
        end
        tick();
        check_out("mul_ff_done", 1, 0, 8'h01, 8'hFE, 1, 0);
        // ADD right after the MUL: c_hi must clear, c wraps to zero
        issue(3'b100, 8'hFF, 8'h01); tick();
        check_out("add_wrap", 1, 0, 8'h00, 8'h00, 1, 1);
        start = 1'b0; tick();
        check("post_add_done", {31'd0, done}, 32'd0);

        // MUL 0x0F*0x03 with an ignored AND mid-multiply
        issue(3'b110, 8'h0F, 8'h03); tick();
        start = 1'b0;
        dones = 0;
        for (int i = 1; i < 8; i++) begin
            if (i == 3) issue(3'b001, 8'hFF, 8'hFF);
            else start = 1'b0;
            tick();
            if (done) dones++;
        end
        start = 1'b0;
        check("mul_0f_nodone", dones, 0);
        tick();
        check_out("mul_0f_done", 1, 0, 8'h2D, 8'h00, 0, 0);
        tick();
        check_out("mul_0f_hold", 0, 0, 8'h2D, 8'h00, 0, 0);

        // Reset at cycle 4 of a MUL
        issue(3'b110, 8'hFF, 8'hFF); tick();
        start = 1'b0;
        repeat (3) tick();
        check("mid_mul_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1; #1;
        check_out("async_reset", 0, 0, 8'h00, 8'h00, 0, 1);
        #1 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (done) dones++;
        end
        check("reset_nodone", dones, 0);
        check_out("after_reset", 0, 0, 8'h00, 8'h00, 0, 1);
        issue(3'b000, 8'h0F, 8'h00); tick();
        start = 1'b0;
        check_out("not_0f", 1, 0, 8'hF0, 8'h00, 0, 0);

        // Back-to-back AND, OR, reserved
        issue(3'b001, 8'hF0, 8'h3C); tick();
        check_out("and", 1, 0, 8'h30, 8'h00, 0, 0);
        issue(3'b010, 8'hF0, 8'h0C); tick();
        check_out("or", 1, 0, 8'hFC, 8'h00, 0, 0);
        issue(3'b111, 8'hAA, 8'h55); tick();
        check_out("reserved", 1, 0, 8'h00, 8'h00, 0, 1);
        start = 1'b0; tick();
        check_out("final_idle", 0, 0, 8'h00, 8'h00, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parameterised, clocked ALU. Accepts one operation per `start` pulse and returns registered results with a `done` strobe. Logic and add/subtract ops complete in one cycle; multiply is a multi-cycle shift-add. It is the datapath engine for the lab processor and replaces free-running combinational arithmetic, so results are stable, flagged and handshaked.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width in bits; legal range is ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only while `busy`=0.
- `a`  in  WIDTH  operand A; captured when `start` is accepted.
- `b`  in  WIDTH  operand B; captured when `start` is accepted.
- `op`  in  3  operation code; captured when `start` is accepted.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse; the result outputs update in the same cycle.
- `c`  out  WIDTH  result, or the low half of the product.
- `c_hi`  out  WIDTH  high half of the product; 0 for every non-MUL op.
- `co`  out  1  carry, borrow or overflow, depending on op.
- `zero`  out  1  high when {`c_hi`,`c`} == 0.

## Operation
Opcodes:
- 000 NOT: `c`=~a, `co`=0.
- 001 AND: `c`=a&b, `co`=0.
- 010 OR: `c`=a|b, `co`=0.
- 011 XOR: `c`=a^b, `co`=0.
- 100 ADD: {`co`,`c`} = a+b, computed at WIDTH+1 bits.
- 101 SUB: `c`=a−b mod 2^WIDTH; `co`=1 when a<b (borrow).
- 110 MUL: {`c_hi`,`c`} = a*b, unsigned, 2·WIDTH bits; `co`=|c_hi (product does not fit in WIDTH bits).
- 111 reserved: `c`=0, `c_hi`=0, `co`=0, `zero`=1.

State machine (IDLE, MUL):
- IDLE, with `start`=1 and op≠110: compute the result and write `c`, `c_hi`, `co`, `zero` at the same edge. Assert `done` for one cycle. Stay in IDLE.
- IDLE, with `start`=1 and op=110: latch a, b and op. Clear the product accumulator and set the iteration count to 0. Go to MUL. `busy`=1.
- MUL: each cycle, test multiplier bit i (LSB first); if it is set, add (a << i) into the 2·WIDTH accumulator; then increment i. At the edge where i reaches WIDTH−1, write the outputs, pulse `done`, and go to IDLE with `busy`=0.
- IDLE, with `start`=0: hold all outputs; `done`=0.

Rules:
- Outputs hold their last value until the next completed operation.
- `a`, `b`, `op` are ignored after capture; changes during MUL have no effect on the result.
- `start` while `busy`=1 is ignored; it is not queued.
- All arithmetic is unsigned and there is no overflow wrap into `co` except as listed per opcode.

## Timing
- Reset value (asynchronous, immediate): state IDLE, `busy`=0, `done`=0, `c`=0, `c_hi`=0, `co`=0, `zero`=1. The accumulator and counter are cleared.
- Single-cycle ops: `start` is sampled at edge k; results and `done`=1 are visible after edge k; `done` drops after edge k+1 unless a new op is accepted.
- MUL: `start` is sampled at edge k; `busy`=1 after edge k; results, `done`=1 and `busy`=0 are visible after edge k+WIDTH. Latency is WIDTH cycles.
- Back-to-back: `start` may be high in the same cycle that `done` is high, because the block is already in IDLE. This gives one op per cycle for non-MUL ops, and a new MUL immediately after a MUL completes.
- Reset mid-MUL: the op is abandoned, no `done` is produced, and all outputs take their reset values.
- `start` held high continuously: a new op is accepted on every IDLE cycle.

## Test plan
- Reset with `start`=0: after `rst`, `c`=0, `c_hi`=0, `co`=0, `zero`=1, `busy`=0, `done`=0.
- WIDTH=8, ADD 0xF0+0x20 → `c`=0x10, `co`=1, `zero`=0, `done` one cycle after `start`. Then SUB 0x05−0x07 → `c`=0xFE, `co`=1. Then XOR 0x5A^0x5A → `c`=0, `zero`=1.
- WIDTH=8, MUL 0xFF*0xFF → `busy` high for 8 cycles, then `c`=0x01, `c_hi`=0xFE, `co`=1, `done` pulses once. Toggle `a`/`b` during the multiply → result unchanged.
- MUL 0x0F*0x03 → `c`=0x2D, `c_hi`=0, `co`=0. A `start` issued mid-multiply with op=001 is ignored: no extra `done`, and the outputs stay at the MUL result.
- Assert `rst` at cycle 4 of a MUL → no `done`, outputs at reset values. A following NOT a=0x0F → `c`=0xF0 one cycle later.
- Back-to-back: AND, OR, then reserved 111 on consecutive cycles → three consecutive `done` pulses. The final result is `c`=0, `co`=0, `zero`=1.
